mips32_mem_arbiter: RTL and testbench

- Single-port instruction/data memory arbiter for the mips32 pipeline.
- Shares one synchronous-read memory between three requesters: IF-stage fetch, MEM-stage load/store, and a debug/loader port used for program preload and register-less inspection.
- Sequences ownership through a small mode FSM (RUN / HALTED / DBG).
- Raises a stall to the pipeline whenever a pipeline request is not granted.

---
 rtl/mips32_pkg.sv | 39 +++
 rtl/mips32_arb_starve.sv | 48 ++++
 rtl/mips32_mem_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
// Shared types and default constants for the mips32 memory arbiter slice.
//   arb_state_t : arbiter mode (RUN / HALTED / DBG)
//   arb_tag_t   : requester tag used for grant winner and read-return routing
//   ARB_AW / ARB_DW / ARB_STARVE_LIMIT : default widths and starvation limit
//   sat_inc16   : saturating 16-bit increment used by the optional statistics
// -----------------------------------------------------------------------------
package mips32_pkg;

    localparam int ARB_AW           = 10;
    localparam int ARB_DW           = 32;
    localparam int ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_DBG    = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_DM   = 2'd2,
        TAG_DBG  = 2'd3
    } arb_tag_t;

    // Saturating increment: sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mips32_arb_starve.sv
// -----------------------------------------------------------------------------
// mips32_arb_starve
// Counts consecutive RUN-mode cycles in which a fetch request was denied and
// raises promote once the count reaches STARVE_LIMIT, so the arbiter can let
// IF win over MEM for one cycle.
// Ports:
//   clk1, rst_n : clock, asynchronous active-low reset
//   in_run      : arbiter is in RUN mode (counter holds otherwise)
//   if_req      : fetch request
//   if_gnt      : fetch granted this cycle
//   promote     : counter has reached STARVE_LIMIT
// -----------------------------------------------------------------------------
module mips32_arb_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic in_run,
    input  logic if_req,
    input  logic if_gnt,
    output logic promote
);

    localparam int             CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT_C = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_r;

    // Starvation counter: counts denied fetches in RUN, saturates, clears on grant or idle.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CW{1'b0}};
        end else if (in_run) begin
            if (if_gnt || !if_req) begin
                starve_cnt_r <= {CW{1'b0}};
            end else if (starve_cnt_r != LIMIT_C) begin
                starve_cnt_r <= starve_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign promote = (starve_cnt_r == LIMIT_C);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips32_mem_arbiter
// Shares one synchronous-read memory between IF fetch, MEM load/store and a
// debug/loader port. A RUN / HALTED / DBG mode FSM decides who may be granted;
// grants are combinational from the requests and the registered mode, and a
// registered read tag routes the one-cycle-latency read data back.
// Ports:
//   clk1, rst_n                     : clock, asynchronous active-low reset
//   halted, dbg_lock                : mode controls (level)
//   if_*  (req/addr -> gnt/rvalid/rdata)             : fetch port (read only)
//   dm_*  (req/we/addr/wdata -> gnt/rvalid/rdata)    : data port
//   dbg_* (req/we/addr/wdata -> gnt/rvalid/rdata)    : debug/loader port
//   mem_en/we/addr/wdata, mem_rdata : memory interface
//   stall_o                         : a pipeline request was denied
// Optional build macro ARB_STATS_EN adds saturating counters if_gnt_cnt,
// dm_gnt_cnt and conflict_cnt, cleared on entry to DBG.
// -----------------------------------------------------------------------------
module mips32_mem_arbiter
    import mips32_pkg::*;
#(
    parameter int AW           = ARB_AW,
    parameter int DW           = ARB_DW,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          dbg_lock,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_o
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   if_gnt_cnt,
    output logic [15:0]   dm_gnt_cnt,
    output logic [15:0]   conflict_cnt
`endif
);

    arb_state_t state_r;
    arb_state_t state_nx_s;
    arb_tag_t   tag_r;
    arb_tag_t   win_s;
    logic       promote_s;

    mips32_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .in_run  (state_r == ST_RUN),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .promote (promote_s)
    );

    // Winner selection: mode decides who is eligible; reset forces no winner.
    always_comb begin
        win_s = TAG_NONE;
        if (!rst_n) begin
            win_s = TAG_NONE;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // A starved fetch gets exactly one cycle ahead of MEM.
                    if (promote_s && if_req) begin
                        win_s = TAG_IF;
                    end else if (dm_req) begin
                        win_s = TAG_DM;
                    end else if (if_req) begin
                        win_s = TAG_IF;
                    end else begin
                        win_s = TAG_NONE;
                    end
                end
                ST_HALTED: begin
                    if (dm_req) begin
                        win_s = TAG_DM;
                    end else begin
                        win_s = TAG_NONE;
                    end
                end
                ST_DBG: begin
                    if (dbg_req) begin
                        win_s = TAG_DBG;
                    end else begin
                        win_s = TAG_NONE;
                    end
                end
                default: win_s = TAG_NONE;
            endcase
        end
    end

    assign if_gnt  = (win_s == TAG_IF);
    assign dm_gnt  = (win_s == TAG_DM);
    assign dbg_gnt = (win_s == TAG_DBG);
    assign stall_o = rst_n & ((if_req & ~if_gnt) | (dm_req & ~dm_gnt));

    // Memory-side mux from the winner; everything zero when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        case (win_s)
            TAG_IF: begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end
            TAG_DM: begin
                mem_en    = 1'b1;
                mem_we    = dm_we;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end
            TAG_DBG: begin
                mem_en    = 1'b1;
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: begin
                mem_en    = 1'b0;
                mem_we    = 1'b0;
                mem_addr  = {AW{1'b0}};
                mem_wdata = {DW{1'b0}};
            end
        endcase
    end

    // Next mode: dbg_lock dominates halted in every state.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (dbg_lock) begin
                    state_nx_s = ST_DBG;
                end else if (halted) begin
                    state_nx_s = ST_HALTED;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (dbg_lock) begin
                    state_nx_s = ST_DBG;
                end else if (!halted) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_HALTED;
                end
            end
            ST_DBG: begin
                if (dbg_lock) begin
                    state_nx_s = ST_DBG;
                end else if (halted) begin
                    state_nx_s = ST_HALTED;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // Mode register and read-return tag; the tag is independent of the mode so a
    // read granted just before a mode change still returns its data.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            tag_r   <= TAG_NONE;
        end else begin
            state_r <= state_nx_s;
            if (mem_en && !mem_we) begin
                tag_r <= win_s;
            end else begin
                tag_r <= TAG_NONE;
            end
        end
    end

    assign if_rvalid  = (tag_r == TAG_IF);
    assign dm_rvalid  = (tag_r == TAG_DM);
    assign dbg_rvalid = (tag_r == TAG_DBG);
    assign if_rdata   = mem_rdata;
    assign dm_rdata   = mem_rdata;
    assign dbg_rdata  = mem_rdata;

`ifdef ARB_STATS_EN
    logic dbg_entry_s;
    assign dbg_entry_s = (state_nx_s == ST_DBG) && (state_r != ST_DBG);

    // Statistics counters: saturating, zeroed whenever DBG is entered.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            if_gnt_cnt   <= 16'd0;
            dm_gnt_cnt   <= 16'd0;
            conflict_cnt <= 16'd0;
        end else if (dbg_entry_s) begin
            if_gnt_cnt   <= 16'd0;
            dm_gnt_cnt   <= 16'd0;
            conflict_cnt <= 16'd0;
        end else begin
            if_gnt_cnt   <= if_gnt ? sat_inc16(if_gnt_cnt) : if_gnt_cnt;
            dm_gnt_cnt   <= dm_gnt ? sat_inc16(dm_gnt_cnt) : dm_gnt_cnt;
            conflict_cnt <= (if_req && dm_req && (state_r == ST_RUN)) ?
                            sat_inc16(conflict_cnt) : conflict_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips32_mem_arbiter
// Directed scoreboard bench: each driven cycle pushes its expected grant /
// memory-strobe / stall record, and every expected read return is pushed to a
// second queue. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_mips32_mem_arbiter;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted = 1'b0;
    logic        if_req = 1'b0;
    logic [9:0]  if_addr = 10'd0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [9:0]  dm_addr = 10'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dbg_lock = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [9:0]  dbg_addr = 10'd0;
    logic [31:0] dbg_wdata = 32'd0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        stall_o;
`ifdef ARB_STATS_EN
    logic [15:0] if_gnt_cnt, dm_gnt_cnt, conflict_cnt;
`endif

    mips32_mem_arbiter dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .halted     (halted),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .dbg_lock   (dbg_lock),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .stall_o    (stall_o)
`ifdef ARB_STATS_EN
        ,
        .if_gnt_cnt   (if_gnt_cnt),
        .dm_gnt_cnt   (dm_gnt_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    // Synchronous-read memory model, preloaded with 32'h1000_0000 + address.
    logic [31:0] mem [0:1023];
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic [2:0]  gnt;     // {if, dm, dbg}
        logic        en;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        stall;
    } grec_t;

    grec_t       gq[$];
    logic [34:0] rq[$];       // {rvalid onehot {if,dm,dbg}, data}
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        rst_v = 1'b0, halted_v = 1'b0, lock_v = 1'b0, drop_read = 1'b0;

    grec_t       ge, ga;
    logic [2:0]  rv;
    logic [34:0] re, ra;

    // Drive one cycle of stimulus and queue what the arbiter must do with it.
    task automatic cyc(input logic ifr, input logic [9:0] ifa,
                       input logic dmr, input logic dmwe, input logic [9:0] dma, input logic [31:0] dmwd,
                       input logic dbgr, input logic dbgwe, input logic [9:0] dbga, input logic [31:0] dbgwd,
                       input logic [2:0] eg, input logic est, input logic [31:0] erd);
        grec_t g;
        @(posedge clk1); #1;
        rst_n = rst_v; halted = halted_v; dbg_lock = lock_v;
        if_req = ifr; if_addr = ifa;
        dm_req = dmr; dm_we = dmwe; dm_addr = dma; dm_wdata = dmwd;
        dbg_req = dbgr; dbg_we = dbgwe; dbg_addr = dbga; dbg_wdata = dbgwd;
        g.gnt   = eg;
        g.en    = |eg;
        g.we    = eg[1] ? dmwe : (eg[0] ? dbgwe : 1'b0);
        g.addr  = eg[2] ? ifa : (eg[1] ? dma : (eg[0] ? dbga : 10'd0));
        g.wdata = g.we ? (eg[1] ? dmwd : dbgwd) : 32'd0;
        g.stall = est;
        gq.push_back(g);
        if ((|eg) && !g.we && !drop_read) rq.push_back({eg, erd});
    endtask

    task automatic idle(input logic [2:0] eg);
        cyc(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, eg, 1'b0, 32'd0);
    endtask

    // Monitor: compare grant record every queued cycle, and any read return.
    always @(negedge clk1) begin
        if (gq.size() > 0) begin
            ge = gq.pop_front();
            ga.gnt   = {if_gnt, dm_gnt, dbg_gnt};
            ga.en    = mem_en;
            ga.we    = mem_we;
            ga.addr  = mem_addr;
            ga.wdata = ge.we ? mem_wdata : 32'd0;
            ga.stall = stall_o;
            n_cmp++;
            if (ga !== ge) begin
                n_bad++;
                $display("FAIL grant @%0t: got gnt=%b en=%b we=%b addr=%h wd=%h stall=%b, expected gnt=%b en=%b we=%b addr=%h wd=%h stall=%b",
                         $time, ga.gnt, ga.en, ga.we, ga.addr, ga.wdata, ga.stall,
                         ge.gnt, ge.en, ge.we, ge.addr, ge.wdata, ge.stall);
            end
        end
        rv = {if_rvalid, dm_rvalid, dbg_rvalid};
        if (rv !== 3'b000) begin
            n_cmp++;
            ra = {rv, (rv == 3'b100) ? if_rdata : ((rv == 3'b010) ? dm_rdata : dbg_rdata)};
            if (rq.size() == 0) begin
                n_bad++;
                $display("FAIL rvalid @%0t: unexpected return %h, expected none", $time, ra);
            end else begin
                re = rq.pop_front();
                if (ra !== re) begin
                    n_bad++;
                    $display("FAIL rdata @%0t: got %h expected %h", $time, ra, re);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;

        // Reset held with a fetch pending: nothing may be granted.
        rst_v = 1'b0;
        cyc(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b000, 1'b0, 32'd0);
        cyc(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b000, 1'b0, 32'd0);
        // Release: fetch granted immediately, data next cycle.
        rst_v = 1'b1;
        cyc(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b100, 1'b0, 32'h1000_0003);
        idle(3'b000);

        // Contention: DM wins 4 times, starved IF promoted on the 5th, then DM.
        for (int k = 0; k < 6; k++) begin
            if (k == 4)
                cyc(1'b1, 10'd8, 1'b1, 1'b0, 10'd9, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b100, 1'b1, 32'h1000_0008);
            else
                cyc(1'b1, 10'd8, 1'b1, 1'b0, 10'd9, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b010, 1'b1, 32'h1000_0009);
        end
        idle(3'b000);
`ifdef ARB_STATS_EN
        n_cmp++;
        if ({if_gnt_cnt, dm_gnt_cnt, conflict_cnt} !== {16'd2, 16'd5, 16'd6}) begin
            n_bad++;
            $display("FAIL stats_run: got %0d/%0d/%0d expected 2/5/6", if_gnt_cnt, dm_gnt_cnt, conflict_cnt);
        end
`endif

        // Store then load through DM; debug request ignored in RUN.
        cyc(1'b0, 10'd0, 1'b1, 1'b1, 10'd20, 32'hDEAD_BEEF, 1'b0, 1'b0, 10'd0, 32'd0, 3'b010, 1'b0, 32'd0);
        cyc(1'b0, 10'd0, 1'b1, 1'b0, 10'd20, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b010, 1'b0, 32'hDEAD_BEEF);
        cyc(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd0, 32'd0, 3'b000, 1'b0, 32'd0);

        // HALTED: store at 5 drains, fetch denied; back to RUN a cycle after halted drops.
        halted_v = 1'b1;
        idle(3'b000);
        cyc(1'b1, 10'd3, 1'b1, 1'b1, 10'd5, 32'h0000_0055, 1'b0, 1'b0, 10'd0, 32'd0, 3'b010, 1'b1, 32'd0);
        cyc(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b000, 1'b1, 32'd0);
        halted_v = 1'b0;
        cyc(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b000, 1'b1, 32'd0);
        cyc(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b100, 1'b0, 32'h1000_0003);

        // DBG: preload word 0 and read it back while pipeline requests stall.
        lock_v = 1'b1;
        idle(3'b000);
        cyc(1'b1, 10'd3, 1'b1, 1'b0, 10'd9, 32'd0, 1'b1, 1'b1, 10'd0, 32'h2801_000A, 3'b001, 1'b1, 32'd0);
`ifdef ARB_STATS_EN
        n_cmp++;
        if ({if_gnt_cnt, dm_gnt_cnt, conflict_cnt} !== 48'd0) begin
            n_bad++;
            $display("FAIL stats_dbg: got %0d/%0d/%0d expected 0/0/0", if_gnt_cnt, dm_gnt_cnt, conflict_cnt);
        end
`endif
        cyc(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd0, 32'd0, 3'b001, 1'b1, 32'h2801_000A);
        idle(3'b000);
        // Read granted in the last DBG cycle returns after the switch to RUN.
        lock_v = 1'b0;
        cyc(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0, 3'b001, 1'b0, 32'h0000_0055);
        cyc(1'b1, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b100, 1'b0, 32'h2801_000A);

        // dbg_lock and halted together: DBG wins, then HALTED once lock drops.
        lock_v = 1'b1; halted_v = 1'b1;
        idle(3'b000);
        cyc(1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0, 1'b1, 1'b0, 10'd20, 32'd0, 3'b001, 1'b1, 32'hDEAD_BEEF);
        lock_v = 1'b0;
        idle(3'b000);
        cyc(1'b1, 10'd3, 1'b1, 1'b0, 10'd5, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b010, 1'b1, 32'h0000_0055);
        halted_v = 1'b0;
        idle(3'b000);

        // Reset between grant and data cycle: the return must be dropped.
        drop_read = 1'b1;
        cyc(1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b100, 1'b0, 32'd0);
        drop_read = 1'b0;
        @(negedge clk1); #1;
        rst_v = 1'b0;
        rst_n = 1'b0;
        idle(3'b000);
        rst_v = 1'b1;
        cyc(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0, 3'b100, 1'b0, 32'h1000_0003);
        idle(3'b000);

        // Drain with a bounded wait, then everything expected must have been seen.
        for (int w = 0; w < 10 && (gq.size() > 0 || rq.size() > 0); w++) @(posedge clk1);
        @(posedge clk1);
        n_cmp++;
        if (gq.size() != 0 || rq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d grant and %0d read expectations left, expected 0", gq.size(), rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
